// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle mult/div sequencer holding HI/LO, with a pipeline stall request
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     E-stage md operation valid; md_op selects mult/multu/div/divu/mthi/mtlo
//   A, B      forwarded rs/rt operands in E
//   md_use_D  D-stage instruction is md-class
//   busy      operation in flight (registered); stall_md: stall request to the pipeline
//   HI, LO    result registers
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        md_go, mt_go, done, a_neg, b_neg;
    logic [63:0] prod;
    logic [31:0] dvd, dvs, quo, rem, res_hi, res_lo;
    assign md_go    = start & ~md_op[2];
    assign mt_go    = start & md_op[2] & ~md_op[1];
    assign done     = state_q == BUSY && cnt_q == 4'd1;
    assign busy     = state_q == BUSY;
    assign stall_md = md_use_D & (busy | md_go);
    assign HI       = hi_q;
    assign LO       = lo_q;
    // Signed ops sign-extend into one 64-bit multiplier (low 64 bits are exact for
    // both signednesses) and divide on magnitudes; the overflow corner falls out
    // naturally as 0x8000_0000 / 1 negated back to 0x8000_0000.
    always_comb begin
        a_neg  = ~op_q[0] & a_q[31];
        b_neg  = ~op_q[0] & b_q[31];
        prod   = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
        dvd    = a_neg ? -a_q : a_q;
        dvs    = b_neg ? -b_q : b_q;
        quo    = dvd / dvs;
        rem    = dvd % dvs;
        res_lo = ~op_q[1] ? prod[31:0]  : b_q == '0 ? '1  : (a_neg ^ b_neg) ? -quo : quo;
        res_hi = ~op_q[1] ? prod[63:32] : b_q == '0 ? a_q : a_neg ? -rem : rem;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE && md_go) begin
            state_d = BUSY;
            cnt_d   = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            op_d    = md_op[1:0];
            a_d     = A;
            b_d     = B;
        end else if (state_q == IDLE && mt_go) begin
            hi_d = md_op[0] ? hi_q : A;
            lo_d = md_op[0] ? A : lo_q;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = done ? IDLE : BUSY;
            hi_d    = done ? res_hi : hi_q;
            lo_d    = done ? res_lo : lo_q;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: randomized self-checking bench for md_scheduler against an arithmetic model
module tb_md_scheduler;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, md_use_D = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = '0, B = '0;
    logic        busy, stall_md;
    logic [31:0] HI, LO;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          errors = 0, checks = 0;
    md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
        .md_use_D(md_use_D), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
    );
    always #5 clk = ~clk;
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      p;
        logic [63:0] pu;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 3'd0) begin
            p = longint'(sa) * longint'(sb);
            h = p[63:32];
            l = p[31:0];
        end else if (op == 3'd1) begin
            pu = {32'b0, a} * {32'b0, b};
            h  = pu[63:32];
            l  = pu[31:0];
        end else if (b == 32'd0) begin
            l = 32'hFFFF_FFFF;
            h = a;
        end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'd0;
        end else if (op == 3'd2) begin
            l = sa / sb;
            h = sa % sb;
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction
    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'h8000_0000;
        if (r == 2) return 32'hFFFF_FFFF;
        if (r == 3) return 32'($urandom_range(1, 20));
        return $urandom;
    endfunction
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input bit poke, input string name);
        logic [31:0] eh, el;
        int n, bad;
        model(op, a, b, eh, el);
        n = op[1] ? DIV_N : MULT_N;
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b; md_use_D = use_d;
        #1;
        checks++;
        if (busy !== 1'b0 || stall_md !== use_d) begin
            errors++;
            $display("FAIL %s start cycle: busy=%b stall_md=%b, want busy=0 stall_md=%b", name, busy, stall_md, use_d);
        end
        bad = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = poke && k == 2;
            md_op = 3'($urandom_range(0, 5));
            A = $urandom;
            B = $urandom;
            #1;
            if (busy !== 1'b1 || stall_md !== use_d || HI !== m_hi || LO !== m_lo) begin
                bad++;
                if (bad == 1)
                    $display("FAIL %s busy cycle %0d: busy=%b stall_md=%b HI=%h LO=%h, want 1 %b %h %h",
                             name, k, busy, stall_md, HI, LO, use_d, m_hi, m_lo);
            end
        end
        checks++;
        if (bad != 0) errors++;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0) begin
            errors++;
            $display("FAIL %s done status: busy=%b stall_md=%b, want 0 0", name, busy, stall_md);
        end
        checks++;
        if (HI !== eh || LO !== el) begin
            errors++;
            $display("FAIL %s result: HI=%h LO=%h, want HI=%h LO=%h", name, HI, LO, eh, el);
        end
        m_hi = eh;
        m_lo = el;
    endtask
    task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input string name);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = $urandom; md_use_D = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: busy=%b stall_md=%b, want 0 0", name, busy, stall_md);
        end
        if (op == 3'd4) m_hi = a;
        if (op == 3'd5) m_lo = a;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL %s write: busy=%b HI=%h LO=%h, want 0 %h %h", name, busy, HI, LO, m_hi, m_lo);
        end
    endtask
    task automatic test_reset();
        md_use_D = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b stall_md=%b HI=%h LO=%h, want 0 0 0 0", busy, stall_md, HI, LO);
        end
    endtask
    task automatic test_mult();
        run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, "mult_neg");
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "multu_max");
        run_md(3'd1, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0, "multu_no_use");
    endtask
    task automatic test_div();
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_neg");
        run_md(3'd3, 32'd100, 32'd0, 1'b1, 1'b0, "divu_zero");
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_ovf");
        run_md(3'd2, 32'd7, 32'd0, 1'b0, 1'b0, "div_zero");
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "divu_big");
    endtask
    task automatic test_mtx();
        run_mt(3'd5, 32'h1234_5678, "mtlo");
        run_mt(3'd4, 32'hCAFE_F00D, "mthi");
        run_mt(3'd6, 32'hDEAD_BEEF, "reserved6");
        run_mt(3'd7, 32'h0BAD_0BAD, "reserved7");
    endtask
    task automatic test_start_during_busy();
        run_md(3'd2, 32'd1000, 32'd7, 1'b1, 1'b1, "div_poke");
        run_md(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, "mult_poke");
    endtask
    task automatic test_reset_mid();
        run_mt(3'd4, 32'hA5A5_A5A5, "mthi_pre");
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; A = 32'd12345; B = 32'd17; md_use_D = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid immediate: busy=%b stall_md=%b HI=%h LO=%h, want 0 0 0 0", busy, stall_md, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (DIV_N + 2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid later: busy=%b HI=%h LO=%h, want 0 0 0", busy, HI, LO);
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) < 7)
                run_md(3'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_md");
            else
                run_mt(3'($urandom_range(4, 7)), $urandom, "rand_mt");
        end
    endtask
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtx();
        test_start_during_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
